// File: rtl/branch_predict_if.sv
// Bundle of fetch-lookup, resolve and statistics signals between the pipeline and the branch predictor.
// master drives lookup/resolve; slave (the predictor) returns prediction, outcome and stats.
interface branch_predict_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  predict_taken;
    logic                  resolve_valid;
    logic [PC_WIDTH-1:0]   resolve_pc;
    logic [2:0]            branch_mode;
    logic                  zero;
    logic                  negative;
    logic                  pred_taken_in;
    logic                  taken;
    logic                  mispredict;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output lookup_pc, resolve_valid, resolve_pc, branch_mode, zero, negative, pred_taken_in,
        input  predict_taken, taken, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, resolve_valid, resolve_pc, branch_mode, zero, negative, pred_taken_in,
        output predict_taken, taken, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution from ALU flags plus a PC-indexed table of 2-bit saturating counters
// for next-PC prediction, with branch and mispredict statistics.
module branch_predict_unit #(
    parameter int         PC_WIDTH   = 32,
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CTR_INIT   = 2'b01,
    parameter int         STAT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_predict_if.slave  bp
);
    localparam int DEPTH = 1 << INDEX_BITS;

    localparam logic [2:0] MODE_NONE = 3'b000;
    localparam logic [2:0] MODE_BEQ  = 3'b001;
    localparam logic [2:0] MODE_BNE  = 3'b010;
    localparam logic [2:0] MODE_BLEZ = 3'b011;
    localparam logic [2:0] MODE_BGTZ = 3'b100;
    localparam logic [2:0] MODE_BLTZ = 3'b101;
    localparam logic [2:0] MODE_BGEZ = 3'b110;
    localparam logic [2:0] MODE_JUMP = 3'b111;

    logic [1:0]            table_q [DEPTH];
    logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] resolve_idx;
    logic                  cond;
    logic                  is_conditional;
    logic                  is_branch;
    logic                  update_en;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_d;

    // Word-aligned PCs: the low two bits never select an entry.
    assign lookup_idx  = bp.lookup_pc[INDEX_BITS+1:2];
    assign resolve_idx = bp.resolve_pc[INDEX_BITS+1:2];

    always_comb begin
        cond = 1'b0;
        case (bp.branch_mode)
            MODE_BEQ:  cond = bp.zero;
            MODE_BNE:  cond = ~bp.zero;
            MODE_BLEZ: cond = bp.negative | bp.zero;
            MODE_BGTZ: cond = ~bp.negative & ~bp.zero;
            MODE_BLTZ: cond = bp.negative;
            MODE_BGEZ: cond = ~bp.negative;
            MODE_JUMP: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end

    assign is_branch      = bp.resolve_valid & (bp.branch_mode != MODE_NONE);
    assign is_conditional = (bp.branch_mode != MODE_NONE) & (bp.branch_mode != MODE_JUMP);
    assign update_en      = bp.resolve_valid & is_conditional;

    assign bp.taken         = bp.resolve_valid & cond;
    assign bp.mispredict    = is_branch & (bp.taken != bp.pred_taken_in);
    assign bp.predict_taken = table_q[lookup_idx][1];

    assign ctr_cur = table_q[resolve_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (bp.taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
    end

    // Statistics wrap naturally at the counter width.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (is_branch)     branch_count_d     = branch_count_q + STAT_WIDTH'(1);
        if (bp.mispredict) mispredict_count_d = mispredict_count_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (update_en) table_q[resolve_idx] <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized checks of branch_predict_unit against a behavioural model
// (signed-result branch conditions, integer saturating counters, modular statistics).
module tb_branch_predict_unit;
    localparam int PC_W   = 32;
    localparam int IDX_B  = 6;
    localparam int STAT_W = 4;
    localparam int DEPTH  = 64;
    localparam int STAT_MOD = 16;

    logic clk;
    logic reset;

    branch_predict_if #(.PC_WIDTH(PC_W), .STAT_WIDTH(STAT_W)) bp_if ();

    branch_predict_unit #(
        .PC_WIDTH(PC_W), .INDEX_BITS(IDX_B), .CTR_INIT(2'b01), .STAT_WIDTH(STAT_W)
    ) dut (
        .clk(clk), .reset(reset), .bp(bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int ctr_m [DEPTH];
    int bc_m;
    int mc_m;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    // Treat flags as describing a signed ALU result and compare it with zero.
    function automatic bit cond_m(input int mode, input bit z, input bit n);
        int v;
        v = z ? 0 : (n ? -1 : 1);
        case (mode)
            1: return v == 0;
            2: return v != 0;
            3: return v <= 0;
            4: return v > 0;
            5: return v < 0;
            6: return v >= 0;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ctr_m[i] = 1;
        bc_m = 0;
        mc_m = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [31:0] rpc, input int mode,
                        input bit z, input bit n, input bit pin, input logic [31:0] lpc,
                        input string tag);
        bit et, em;
        reset                = rst;
        bp_if.resolve_valid  = v;
        bp_if.resolve_pc     = rpc;
        bp_if.branch_mode    = 3'(mode);
        bp_if.zero           = z;
        bp_if.negative       = n;
        bp_if.pred_taken_in  = pin;
        bp_if.lookup_pc      = lpc;
        #1;
        et = v && cond_m(mode, z, n);
        em = v && (mode != 0) && (et != pin);
        chk({tag, "_predict"}, 32'(bp_if.predict_taken), 32'(ctr_m[idx_of(lpc)] >= 2));
        chk({tag, "_taken"}, 32'(bp_if.taken), 32'(et));
        chk({tag, "_mispredict"}, 32'(bp_if.mispredict), 32'(em));
        chk({tag, "_bcount"}, 32'(bp_if.branch_count), 32'(bc_m));
        chk({tag, "_mcount"}, 32'(bp_if.mispredict_count), 32'(mc_m));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (v && mode >= 1 && mode <= 6) begin
                if (et) ctr_m[idx_of(rpc)] = (ctr_m[idx_of(rpc)] < 3) ? ctr_m[idx_of(rpc)] + 1 : 3;
                else    ctr_m[idx_of(rpc)] = (ctr_m[idx_of(rpc)] > 0) ? ctr_m[idx_of(rpc)] - 1 : 0;
            end
            if (v && mode != 0) bc_m = (bc_m + 1) % STAT_MOD;
            if (em) mc_m = (mc_m + 1) % STAT_MOD;
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [31:0] lpc, input bit exp, input string tag);
        reset               = 1'b0;
        bp_if.resolve_valid = 1'b0;
        bp_if.branch_mode   = 3'd0;
        bp_if.lookup_pc     = lpc;
        #1;
        chk(tag, 32'(bp_if.predict_taken), 32'(exp));
    endtask

    initial begin
        int zn, mode, psel;
        logic [31:0] pc;
        reset = 1'b1;
        bp_if.resolve_valid = 1'b0;
        bp_if.resolve_pc    = '0;
        bp_if.branch_mode   = 3'd0;
        bp_if.zero          = 1'b0;
        bp_if.negative      = 1'b0;
        bp_if.pred_taken_in = 1'b0;
        bp_if.lookup_pc     = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // 1: reset state
        step(0, 0, 32'h0, 0, 0, 0, 0, 32'h1234, "t1_idle");
        peek(32'h40, 1'b0, "t1_pred40");
        chk("t1_bcount0", 32'(bp_if.branch_count), 32'd0);
        chk("t1_mcount0", 32'(bp_if.mispredict_count), 32'd0);

        // 2: mode table over flag combinations 00, 01, 10
        for (int m = 0; m < 8; m++)
            for (int f = 0; f < 3; f++)
                step(0, 1, 32'h200 + 32'(m * 4), m, f == 2, f == 1, 0, 32'h0, "t2_mode");

        // 3: training at 0x40
        step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, "t3_rst");
        step(0, 1, 32'h40, 1, 1, 0, 0, 32'h40, "t3_up1");
        peek(32'h40, 1'b1, "t3_pred_after1");
        step(0, 1, 32'h40, 1, 1, 0, 1, 32'h40, "t3_up2");
        step(0, 1, 32'h40, 1, 1, 0, 1, 32'h40, "t3_up3");
        step(0, 1, 32'h40, 1, 0, 0, 1, 32'h40, "t3_nt1");
        peek(32'h40, 1'b1, "t3_pred_after_nt1");
        step(0, 1, 32'h40, 1, 0, 0, 1, 32'h40, "t3_nt2");
        peek(32'h40, 1'b0, "t3_pred_after_nt2");

        // 4: aliasing between 0x40 and 0x140
        step(0, 1, 32'h40, 1, 1, 0, 0, 32'h140, "t4_train40");
        peek(32'h140, 1'b1, "t4_alias_pred");
        step(0, 1, 32'h140, 2, 1, 0, 1, 32'h40, "t4_train140");
        peek(32'h40, 1'b0, "t4_alias_back");

        // 5: mispredict accounting, JUMP, mode 000
        step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, "t5_rst");
        step(0, 1, 32'h80, 2, 0, 0, 0, 32'h80, "t5_bne");
        chk("t5_bc1", 32'(bp_if.branch_count), 32'd1);
        chk("t5_mc1", 32'(bp_if.mispredict_count), 32'd1);
        step(0, 1, 32'h84, 7, 0, 0, 1, 32'h84, "t5_jump");
        peek(32'h84, 1'b0, "t5_jump_no_train");
        step(0, 1, 32'h88, 0, 1, 0, 1, 32'h88, "t5_none");
        chk("t5_bc2", 32'(bp_if.branch_count), 32'd2);
        chk("t5_mc1b", 32'(bp_if.mispredict_count), 32'd1);

        // 6: reset dominates an update; statistics wrap
        step(1, 1, 32'h40, 1, 1, 0, 0, 32'h40, "t6_rst_upd");
        peek(32'h40, 1'b0, "t6_init_pred");
        chk("t6_bc0", 32'(bp_if.branch_count), 32'd0);
        for (int i = 0; i < STAT_MOD; i++)
            step(0, 1, 32'hC0, 6, 0, 0, 1, 32'hC0, "t6_wrap");
        chk("t6_bc_wrapped", 32'(bp_if.branch_count), 32'd0);

        // randomized traffic over a handful of PCs including an aliasing pair
        for (int i = 0; i < 400; i++) begin
            psel = int'($urandom_range(0, 4));
            case (psel)
                0: pc = 32'h40;
                1: pc = 32'h140;
                2: pc = 32'h80;
                default: pc = $urandom;
            endcase
            mode = int'($urandom_range(0, 7));
            zn   = int'($urandom_range(0, 2));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, pc, mode,
                 zn == 2, zn == 1, 1'($urandom), ($urandom_range(0, 1) != 0) ? pc : 32'h140,
                 "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
